// File: rtl/xcore_wb_ctrl.sv
// Writeback stage behind commit: buffers GPR writebacks in a small FIFO that drains to the single
// regfile write port (debug writes win the port), holds one CSR write, and forwards pending GPR data.
module xcore_wb_ctrl #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            i_sys_clk,
  input  logic            i_sys_rst_n,
  input  logic            i_cmt_wrbk_req,
  input  logic [4:0]      i_cmt_wrbk_addr,
  input  logic [XLEN-1:0] i_cmt_wrbk_data,
  input  logic            i_cmt_wcsr_req,
  input  logic [11:0]     i_cmt_wcsr_addr,
  input  logic [XLEN-1:0] i_cmt_wcsr_data,
  input  logic            i_dbg_wr_req,
  input  logic [4:0]      i_dbg_wr_addr,
  input  logic [XLEN-1:0] i_dbg_wr_data,
  input  logic            i_csr_wr_rdy,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  output logic            o_wb_stall,
  output logic            o_rf_wr_en,
  output logic [4:0]      o_rf_wr_addr,
  output logic [XLEN-1:0] o_rf_wr_data,
  output logic            o_csr_wr_en,
  output logic [11:0]     o_csr_wr_addr,
  output logic [XLEN-1:0] o_csr_wr_data,
  output logic            o_rs1_fwd_vld,
  output logic [XLEN-1:0] o_rs1_fwd_data,
  output logic            o_rs2_fwd_vld,
  output logic [XLEN-1:0] o_rs2_fwd_data,
  output logic            o_wb_ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {CSR_FREE, CSR_BUSY} csr_state_e;

  logic [4:0]      fifo_addr [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic            push_req, push, pop, full;

  csr_state_e      csr_state, csr_state_next;
  logic            csr_load;
  logic [11:0]     csr_addr_q;
  logic [XLEN-1:0] csr_data_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // x0 writes never enter the FIFO; a full FIFO still accepts when the head leaves this cycle.
  assign push_req   = i_cmt_wrbk_req & (i_cmt_wrbk_addr != 5'd0);
  assign pop        = (count != '0) & ~i_dbg_wr_req;
  assign full       = (count == CW'(DEPTH));
  assign push       = push_req & (~full | pop);
  assign count_next = count + CW'(push) - CW'(pop);

  // NOTE: FIFO storage has no reset; count and pointers alone define which entries are valid.
  always_ff @(posedge i_sys_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= i_cmt_wrbk_addr;
      fifo_data[wr_ptr] <= i_cmt_wrbk_data;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_wb_ovf   <= 1'b0;
      o_wb_stall <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next;
      if (push_req & full & ~pop) o_wb_ovf <= 1'b1;
      // Leaves one free slot for the single request commit may still issue under stall.
      o_wb_stall <= (count_next >= CW'(DEPTH - 1)) | (csr_state_next == CSR_BUSY);
    end
  end

  always_comb begin
    o_rf_wr_en   = 1'b0;
    o_rf_wr_addr = '0;
    o_rf_wr_data = '0;
    if (i_dbg_wr_req) begin
      if (i_dbg_wr_addr != 5'd0) begin
        o_rf_wr_en   = 1'b1;
        o_rf_wr_addr = i_dbg_wr_addr;
        o_rf_wr_data = i_dbg_wr_data;
      end
    end else if (count != '0) begin
      o_rf_wr_en   = 1'b1;
      o_rf_wr_addr = fifo_addr[rd_ptr];
      o_rf_wr_data = fifo_data[rd_ptr];
    end
  end

  // Walks valid entries oldest to youngest so the youngest match overrides.
  function automatic logic [XLEN:0] fwd_lookup(input logic [4:0] rs);
    logic [XLEN:0] res;
    logic [PW:0]   idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = {1'b0, rd_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(DEPTH)) idx = idx - (PW+1)'(DEPTH);
      if ((CW'(i) < count) && (rs != 5'd0) && (fifo_addr[idx[PW-1:0]] == rs))
        res = {1'b1, fifo_data[idx[PW-1:0]]};
    end
    return res;
  endfunction

  always_comb begin
    {o_rs1_fwd_vld, o_rs1_fwd_data} = fwd_lookup(i_rs1_addr);
    {o_rs2_fwd_vld, o_rs2_fwd_data} = fwd_lookup(i_rs2_addr);
  end

  // CSR holding register: a request in the release cycle reloads it back-to-back.
  assign csr_load = i_cmt_wcsr_req & ((csr_state == CSR_FREE) | i_csr_wr_rdy);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      csr_state  <= CSR_FREE;
      csr_addr_q <= '0;
      csr_data_q <= '0;
    end else begin
      csr_state <= csr_state_next;
      if (csr_load) begin
        csr_addr_q <= i_cmt_wcsr_addr;
        csr_data_q <= i_cmt_wcsr_data;
      end
    end
  end

  always_comb begin
    csr_state_next = csr_state;
    case (csr_state)
      CSR_FREE: if (csr_load) csr_state_next = CSR_BUSY;
      CSR_BUSY: if (i_csr_wr_rdy && !csr_load) csr_state_next = CSR_FREE;
      default:  csr_state_next = CSR_FREE;
    endcase
  end

  always_comb begin
    o_csr_wr_en   = (csr_state == CSR_BUSY);
    o_csr_wr_addr = o_csr_wr_en ? csr_addr_q : '0;
    o_csr_wr_data = o_csr_wr_en ? csr_data_q : '0;
  end

endmodule
